// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: runs loads/stores over a req/ack data-memory
// port, stalls the front end while an access is outstanding, and owns the MEM/WB register.
module mem_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwrite_mem,
  input  logic             memtoreg_mem,
  input  logic             memwrite_mem,
  input  logic [WIDTH-1:0] aluout_mem,
  input  logic [WIDTH-1:0] writedata_mem,
  input  logic [4:0]       regaddr_mem,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             mem_stall,
  output logic             regwrite_wb,
  output logic             memtoreg_wb,
  output logic [WIDTH-1:0] aluout_wb,
  output logic [WIDTH-1:0] readdata_wb,
  output logic [4:0]       regaddr_wb,
  output logic             misalign_err,
  output logic             bus_err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // access latched at issue; the upstream copy is not trusted once BUSY
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             rw_q, rw_d;
  logic             mtr_q, mtr_d;
  logic [4:0]       ra_q, ra_d;

  // MEM/WB register
  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic [4:0]       regaddr_q, regaddr_d;
  logic             mis_q, mis_d;
  logic             berr_q, berr_d;

  logic acc, misaligned;

  assign acc        = memtoreg_mem | memwrite_mem;
  assign misaligned = |aluout_mem[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rw_d       = rw_q;
    mtr_d      = mtr_q;
    ra_d       = ra_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    aluout_d   = aluout_q;
    readdata_d = readdata_q;
    regaddr_d  = regaddr_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    mem_stall  = 1'b0;

    if (state_q == IDLE) begin
      if (!acc) begin
        regwrite_d = regwrite_mem;
        memtoreg_d = 1'b0;
        aluout_d   = aluout_mem;
        regaddr_d  = regaddr_mem;
      end else if (misaligned) begin
        mis_d      = 1'b1;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
      end else begin
        mem_stall  = 1'b1;
        addr_d     = aluout_mem;
        wdata_d    = writedata_mem;
        we_d       = memwrite_mem;
        rw_d       = regwrite_mem;
        // a store wins when both load and store flags are set
        mtr_d      = memtoreg_mem & ~memwrite_mem;
        ra_d       = regaddr_mem;
        cnt_d      = '0;
        state_d    = BUSY;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
      end
    end else begin
      // bubble into MEM/WB on every cycle that does not complete the access
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      if (dmem_ack) begin
        regwrite_d = rw_q & ~we_q;
        memtoreg_d = mtr_q;
        aluout_d   = addr_q;
        regaddr_d  = ra_q;
        if (!we_q) readdata_d = dmem_rdata;
        state_d    = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        berr_d     = 1'b1;
        state_d    = IDLE;
      end else begin
        mem_stall  = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rw_q       <= 1'b0;
      mtr_q      <= 1'b0;
      ra_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      aluout_q   <= '0;
      readdata_q <= '0;
      regaddr_q  <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rw_q       <= rw_d;
      mtr_q      <= mtr_d;
      ra_q       <= ra_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      aluout_q   <= aluout_d;
      readdata_q <= readdata_d;
      regaddr_q  <= regaddr_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  // request is a pure function of state, so it is held through the abort cycle
  assign dmem_req     = (state_q == BUSY);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign regwrite_wb  = regwrite_q;
  assign memtoreg_wb  = memtoreg_q;
  assign aluout_wb    = aluout_q;
  assign readdata_wb  = readdata_q;
  assign regaddr_wb   = regaddr_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4: inputs change on negedge, registered
// outputs are sampled 1ns after posedge, combinational outputs 1ns after negedge.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [31:0] aluout_mem, writedata_mem;
  logic [4:0]  regaddr_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, mem_stall;
  logic        regwrite_wb, memtoreg_wb;
  logic [31:0] aluout_wb, readdata_wb;
  logic [4:0]  regaddr_wb;
  logic        misalign_err, bus_err;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .regaddr_mem(regaddr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb), .aluout_wb(aluout_wb),
    .readdata_wb(readdata_wb), .regaddr_wb(regaddr_wb),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic mtr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] ra);
    regwrite_mem = rw; memtoreg_mem = mtr; memwrite_mem = mw;
    aluout_mem = alu; writedata_mem = wd; regaddr_mem = ra;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({regwrite_wb, memtoreg_wb} !== 2'b00) begin n_err++; $display("FAIL reset_ctl: got %b exp 00", {regwrite_wb, memtoreg_wb}); end
    n_vec++; if ({aluout_wb, readdata_wb} !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0", {aluout_wb, readdata_wb}); end
    n_vec++; if (regaddr_wb !== 5'd0) begin n_err++; $display("FAIL reset_ra: got %0d exp 0", regaddr_wb); end
    n_vec++; if ({dmem_req, dmem_we, mem_stall, misalign_err, bus_err} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b exp 00000", {dmem_req, dmem_we, mem_stall, misalign_err, bus_err}); end
    n_vec++; if ({dmem_addr, dmem_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus: got %h exp 0", {dmem_addr, dmem_wdata}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_rtype();
    @(negedge clk); drive(1, 0, 0, 32'h1234, 32'h0, 5'd5);
    #1;
    n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rtype_stall: got %b exp 0", mem_stall); end
    @(posedge clk); #1;
    n_vec++; if ({regwrite_wb, memtoreg_wb} !== 2'b10) begin n_err++; $display("FAIL rtype_ctl: got %b exp 10", {regwrite_wb, memtoreg_wb}); end
    n_vec++; if (aluout_wb !== 32'h1234) begin n_err++; $display("FAIL rtype_alu: got %h exp 1234", aluout_wb); end
    n_vec++; if (regaddr_wb !== 5'd5) begin n_err++; $display("FAIL rtype_ra: got %0d exp 5", regaddr_wb); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    @(negedge clk); drive(1, 1, 0, 32'h40, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_stall) stalls++;
      if (i > 0) begin
        n_vec++; if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h40}) begin n_err++; $display("FAIL ld_wait%0d: got req/we/addr %b%b/%h exp 10/40", i, dmem_req, dmem_we, dmem_addr); end
      end
      @(posedge clk); #1;
      n_vec++; if (regwrite_wb !== 1'b0) begin n_err++; $display("FAIL ld_bubble%0d: got %b exp 0", i, regwrite_wb); end
      // upstream contents must not leak into the latched access
      @(negedge clk); drive(1, 0, 1, 32'h999, 32'h77, 5'd3);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    n_vec++; if ({mem_stall, dmem_req} !== 2'b01) begin n_err++; $display("FAIL ld_ackcyc: got stall/req %b%b exp 01", mem_stall, dmem_req); end
    n_vec++; if (stalls !== 4) begin n_err++; $display("FAIL ld_stalls: got %0d exp 4", stalls); end
    @(posedge clk); #1;
    n_vec++; if ({regwrite_wb, memtoreg_wb, dmem_req} !== 3'b110) begin n_err++; $display("FAIL ld_ctl: got %b exp 110", {regwrite_wb, memtoreg_wb, dmem_req}); end
    n_vec++; if (readdata_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_data: got %h exp deadbeef", readdata_wb); end
    n_vec++; if ({regaddr_wb, aluout_wb} !== {5'd7, 32'h40}) begin n_err++; $display("FAIL ld_ra_alu: got %0d/%h exp 7/40", regaddr_wb, aluout_wb); end
    @(negedge clk); dmem_ack = 1'b0; drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_store();
    @(negedge clk); drive(1, 0, 1, 32'h80, 32'hCAFE, 5'd9);
    #1;
    n_vec++; if ({mem_stall, dmem_req} !== 2'b10) begin n_err++; $display("FAIL st_issue: got stall/req %b%b exp 10", mem_stall, dmem_req); end
    @(posedge clk);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h1111;
    #1;
    n_vec++; if ({dmem_req, dmem_we, mem_stall} !== 3'b110) begin n_err++; $display("FAIL st_bus: got req/we/stall %b exp 110", {dmem_req, dmem_we, mem_stall}); end
    n_vec++; if ({dmem_addr, dmem_wdata} !== {32'h80, 32'hCAFE}) begin n_err++; $display("FAIL st_addr_data: got %h/%h exp 80/cafe", dmem_addr, dmem_wdata); end
    @(posedge clk); #1;
    n_vec++; if ({regwrite_wb, memtoreg_wb} !== 2'b00) begin n_err++; $display("FAIL st_ctl: got %b exp 00", {regwrite_wb, memtoreg_wb}); end
    n_vec++; if (readdata_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL st_rdkeep: got %h exp deadbeef", readdata_wb); end
    @(negedge clk); dmem_ack = 1'b0; drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    @(negedge clk); drive(1, 1, 0, 32'h42, 32'h0, 5'd4);
    #1;
    n_vec++; if ({mem_stall, dmem_req} !== 2'b00) begin n_err++; $display("FAIL mis_stall: got stall/req %b%b exp 00", mem_stall, dmem_req); end
    @(posedge clk); #1;
    n_vec++; if ({misalign_err, regwrite_wb, memtoreg_wb, dmem_req} !== 4'b1000) begin n_err++; $display("FAIL mis_pulse: got %b exp 1000", {misalign_err, regwrite_wb, memtoreg_wb, dmem_req}); end
    // a stray ack while idle must be ignored
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    n_vec++; if ({misalign_err, dmem_req} !== 2'b00) begin n_err++; $display("FAIL mis_end: got err/req %b exp 00", {misalign_err, dmem_req}); end
    n_vec++; if (readdata_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_ack: got %h exp deadbeef", readdata_wb); end
    @(negedge clk); dmem_ack = 1'b0;
  endtask

  task automatic test_timeout(input logic with_ack);
    logic exp_stall, exp_req;
    @(negedge clk); drive(1, 1, 0, 32'h100, 32'h0, 5'd8);
    for (int i = 0; i < 5; i++) begin
      if (i == 4 && with_ack) begin dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA; end
      #1;
      exp_stall = (i < 4);
      exp_req   = (i > 0);
      n_vec++; if ({mem_stall, dmem_req} !== {exp_stall, exp_req}) begin n_err++; $display("FAIL to%0d_cyc%0d: got stall/req %b%b exp %b%b", with_ack, i, mem_stall, dmem_req, exp_stall, exp_req); end
      @(posedge clk);
      if (i < 4) @(negedge clk);
    end
    #1;
    if (with_ack) begin
      n_vec++; if ({bus_err, regwrite_wb, memtoreg_wb, dmem_req} !== 4'b0110) begin n_err++; $display("FAIL to_ackwin: got %b exp 0110", {bus_err, regwrite_wb, memtoreg_wb, dmem_req}); end
      n_vec++; if ({readdata_wb, regaddr_wb} !== {32'h55AA55AA, 5'd8}) begin n_err++; $display("FAIL to_ackdata: got %h/%0d exp 55aa55aa/8", readdata_wb, regaddr_wb); end
    end else begin
      n_vec++; if ({bus_err, regwrite_wb, memtoreg_wb, dmem_req} !== 4'b1000) begin n_err++; $display("FAIL to_abort: got %b exp 1000", {bus_err, regwrite_wb, memtoreg_wb, dmem_req}); end
    end
    @(negedge clk); dmem_ack = 1'b0; drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_vec++; if ({bus_err, dmem_req} !== 2'b00) begin n_err++; $display("FAIL to_after%0d: got err/req %b exp 00", with_ack, {bus_err, dmem_req}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1, 1, 0, 32'h200, 32'h0, 5'd10);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got req %b exp 1", dmem_req); end
    @(posedge clk); #1;
    n_vec++; if ({dmem_req, bus_err, regwrite_wb, memtoreg_wb} !== 4'b0000) begin n_err++; $display("FAIL rstmid_ctl: got %b exp 0000", {dmem_req, bus_err, regwrite_wb, memtoreg_wb}); end
    n_vec++; if ({readdata_wb, aluout_wb, regaddr_wb} !== 69'h0) begin n_err++; $display("FAIL rstmid_data: got %h/%h/%0d exp 0", readdata_wb, aluout_wb, regaddr_wb); end
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive(1, 1, 0, 32'h10, 32'h0, 5'd11);
    #1;
    n_vec++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL b2b_issueA: got %b exp 1", mem_stall); end
    @(posedge clk);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hA0A0;
    @(posedge clk); #1;
    n_vec++; if ({readdata_wb, regaddr_wb} !== {32'hA0A0, 5'd11}) begin n_err++; $display("FAIL b2b_A: got %h/%0d exp a0a0/11", readdata_wb, regaddr_wb); end
    @(negedge clk); dmem_ack = 1'b0; drive(1, 1, 0, 32'h14, 32'h0, 5'd12);
    #1;
    n_vec++; if ({mem_stall, dmem_req} !== 2'b10) begin n_err++; $display("FAIL b2b_issueB: got stall/req %b%b exp 10", mem_stall, dmem_req); end
    @(posedge clk);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'hB0B0;
    #1;
    n_vec++; if (dmem_addr !== 32'h14) begin n_err++; $display("FAIL b2b_addrB: got %h exp 14", dmem_addr); end
    @(posedge clk); #1;
    n_vec++; if ({readdata_wb, regaddr_wb, memtoreg_wb} !== {32'hB0B0, 5'd12, 1'b1}) begin n_err++; $display("FAIL b2b_B: got %h/%0d/%b exp b0b0/12/1", readdata_wb, regaddr_wb, memtoreg_wb); end
    @(negedge clk); dmem_ack = 1'b0; drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_misalign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EXE/MEM pipeline register. It consumes that register's outputs and runs loads and stores against a handshaked data-memory port. It stalls the front of the pipeline while an access is outstanding and produces the registered MEM/WB state consumed by writeback.

## Interface
Parameters:
- `WIDTH`, 32, datapath width (matches `` `WIDTH ``)
- `TIMEOUT`, 15, max cycles to wait for `dmem_ack` before aborting; legal range 1..255

Ports. One clock; reset is synchronous and active-high.
- `clk` input 1: pipeline clock; all state updates on the rising edge
- `rst` input 1: synchronous, active-high reset
- `regwrite_mem` input 1: from EXE/MEM; instruction writes the register file
- `memtoreg_mem` input 1: from EXE/MEM; instruction is a load
- `memwrite_mem` input 1: from EXE/MEM; instruction is a store
- `aluout_mem` input WIDTH: from EXE/MEM; effective address or ALU result
- `writedata_mem` input WIDTH: from EXE/MEM; store data
- `regaddr_mem` input 5: from EXE/MEM; destination register
- `dmem_req` output 1: access request, held until ack or abort
- `dmem_we` output 1: 1 = store, 0 = load; valid while `dmem_req`
- `dmem_addr` output WIDTH: latched word-aligned byte address
- `dmem_wdata` output WIDTH: latched store data
- `dmem_rdata` input WIDTH: load data; valid in the cycle `dmem_ack` = 1
- `dmem_ack` input 1: access complete; ignored when `dmem_req` = 0
- `mem_stall` output 1, combinational: hold PC, IF/ID, ID/EXE and EXE/MEM
- `regwrite_wb` output 1: MEM/WB registered control
- `memtoreg_wb` output 1: MEM/WB registered control
- `aluout_wb` output WIDTH: MEM/WB ALU result
- `readdata_wb` output WIDTH: MEM/WB load data
- `regaddr_wb` output 5: MEM/WB destination register
- `misalign_err` output 1: one-cycle pulse; access had `aluout_mem[1:0]` ≠ 0
- `bus_err` output 1: one-cycle pulse; access timed out

## Operation
- Access condition: `acc = memtoreg_mem | memwrite_mem`. `memwrite_mem` has priority if both inputs are set.
- FSM has two states, IDLE and BUSY.
- IDLE, `acc` = 0: MEM/WB loads `{regwrite_mem, memtoreg_mem=0, aluout_mem, readdata_wb unchanged, regaddr_mem}`. No stall.
- IDLE, `acc` = 1, `aluout_mem[1:0]` ≠ 0:
  - no bus access
  - pulse `misalign_err`
  - MEM/WB loads a bubble: `regwrite_wb`=0, `memtoreg_wb`=0
  - no stall; the instruction is dropped
- IDLE, `acc` = 1, aligned:
  - `mem_stall` = 1
  - latch addr, wdata, we and the wb control fields
  - clear the timeout counter
  - go to BUSY
  - MEM/WB loads a bubble
- BUSY: `dmem_req` = 1 and `mem_stall` = 1, except in the ack cycle.
- BUSY with `dmem_ack` = 1:
  - `mem_stall` = 0
  - MEM/WB loads the latched fields
  - `readdata_wb` = `dmem_rdata` for a load
  - a store forces `regwrite_wb` = 0
  - go to IDLE
- BUSY with `dmem_ack` = 0:
  - counter increments
  - when the counter reaches TIMEOUT-1 without ack: pulse `bus_err`, drop `dmem_req`, load a bubble into MEM/WB, deassert stall, go to IDLE
  - this is the abort cycle; the access is abandoned
- Counter is `$clog2(TIMEOUT+1)` bits wide and saturates; no wrap.
- `dmem_addr`, `dmem_wdata` and `dmem_we` are stable for the whole BUSY period, independent of the inputs.
- `dmem_ack` arriving in IDLE is ignored.

## Timing
- Reset values:
  - FSM IDLE
  - `dmem_req` 0, `dmem_we` 0, `dmem_addr` 0, `dmem_wdata` 0
  - all `*_wb` outputs 0
  - `misalign_err` 0, `bus_err` 0
  - counter 0
  - `mem_stall` 0 (IDLE with reset-zero inputs)
- Non-memory instruction: 1 cycle, EXE/MEM to MEM/WB.
- Load or store with ack in its first BUSY cycle: 2 cycles, with 1 stall cycle. Each extra wait cycle adds 1.
- Timeout: the abort happens in BUSY cycle TIMEOUT. `mem_stall` is high for TIMEOUT cycles in total (the IDLE issue cycle plus TIMEOUT-1 BUSY cycles).
- Stall is asserted combinationally in the IDLE issue cycle so the upstream register holds the same instruction. Therefore this block must not re-issue it: the latched copy is used, and the FSM is in BUSY.
- Ack and timeout in the same cycle: ack wins, normal completion, no `bus_err`.
- Back-to-back loads: the second load issues in the cycle after the first completes. No idle gap beyond its own issue cycle.
- Reset mid-access: at the next edge the FSM goes to IDLE and `dmem_req` goes to 0. The access is abandoned with no error pulse.

## Test plan
- Reset, then an R-type instruction (`regwrite_mem`=1, `aluout_mem`=0x1234, `regaddr_mem`=5) → next cycle `regwrite_wb`=1, `aluout_wb`=0x1234, `regaddr_wb`=5; `mem_stall` never 1.
- Load from 0x40, ack after 3 wait cycles with rdata 0xDEADBEEF → stall high 4 cycles, then `memtoreg_wb`=1, `readdata_wb`=0xDEADBEEF, `regaddr_wb` correct; `dmem_addr` = 0x40 throughout.
- Store of 0xCAFE to 0x80, ack on the first BUSY cycle → `dmem_we`=1, `dmem_wdata`=0xCAFE, 1 stall cycle, `regwrite_wb`=0.
- Load to 0x42 → `misalign_err` pulses for 1 cycle, `dmem_req` stays 0, MEM/WB is a bubble, no stall.
- Load with no ack, TIMEOUT=4 → stall for 4 cycles, `bus_err` pulses once, `dmem_req` falls, bubble in MEM/WB. Repeat with ack arriving in the abort cycle → normal completion, no `bus_err`.
- Assert `rst` in the second BUSY cycle → `dmem_req`=0 and all wb outputs 0 on the next edge. A later load completes normally.
